// File: rtl/frontend_linebuf_writer.sv
// frontend_linebuf_writer: captures active video into a ring of line slots, publishing line-commit
// and frame-start events while tracking slot occupancy through a consumer release handshake.
module frontend_linebuf_writer #(
    parameter int SLOT_BITS = 2
) (
    input  logic                   PCLK_i,
    input  logic                   reset_n,
    input  logic                   enable_i,
    input  logic [7:0]             R_i,
    input  logic [7:0]             G_i,
    input  logic [7:0]             B_i,
    input  logic                   VSYNC_i,
    input  logic                   DE_i,
    input  logic                   FID_i,
    input  logic [10:0]            xpos_i,
    input  logic [10:0]            ypos_i,
    input  logic                   release_i,
    output logic                   wr_en_o,
    output logic [SLOT_BITS+10:0]  wr_addr_o,
    output logic [23:0]            wr_data_o,
    output logic                   line_done_o,
    output logic [SLOT_BITS-1:0]   line_slot_o,
    output logic [10:0]            line_ypos_o,
    output logic [11:0]            line_len_o,
    output logic                   frame_start_o,
    output logic                   frame_fid_o,
    output logic [SLOT_BITS:0]     occupancy_o,
    output logic [7:0]             drop_cnt_o,
    output logic                   overflow_o
);
    localparam int SLOTS = 1 << SLOT_BITS;

    typedef enum logic [1:0] {IDLE, WAIT_LINE, WRITE, DROP} state_t;

    state_t                r_state, w_next;
    logic                  r_vs_prev, r_de_prev;
    logic [SLOT_BITS-1:0]  r_slot;
    logic [11:0]           r_len;
    logic [10:0]           r_ypos;
    logic                  w_fs, w_rise, w_full, w_rel;
    logic                  w_accept, w_drop, w_wr, w_commit;

    assign w_fs   = enable_i & r_vs_prev & ~VSYNC_i;
    assign w_rise = DE_i & ~r_de_prev;
    assign w_full = occupancy_o == (SLOT_BITS+1)'(SLOTS);
    assign w_rel  = release_i && occupancy_o != '0;

    // Frame start and disable override every per-line transition.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_drop   = 1'b0;
        w_wr     = 1'b0;
        w_commit = 1'b0;
        if (!enable_i)
            w_next = IDLE;
        else if (w_fs)
            w_next = WAIT_LINE;
        else
            case (r_state)
                WAIT_LINE: if (w_rise) begin
                    w_accept = ~w_full;
                    w_drop   = w_full;
                    w_wr     = ~w_full;
                    w_next   = w_full ? DROP : WRITE;
                end
                WRITE: begin
                    w_wr     = DE_i;
                    w_commit = ~DE_i;
                    w_next   = DE_i ? WRITE : WAIT_LINE;
                end
                DROP:    w_next = DE_i ? DROP : WAIT_LINE;
                default: w_next = r_state;
            endcase
    end

    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_vs_prev     <= 1'b0;
            r_de_prev     <= 1'b0;
            r_slot        <= '0;
            r_len         <= '0;
            r_ypos        <= '0;
            wr_en_o       <= 1'b0;
            wr_addr_o     <= '0;
            wr_data_o     <= '0;
            line_done_o   <= 1'b0;
            line_slot_o   <= '0;
            line_ypos_o   <= '0;
            line_len_o    <= '0;
            frame_start_o <= 1'b0;
            frame_fid_o   <= 1'b0;
            occupancy_o   <= '0;
            drop_cnt_o    <= '0;
            overflow_o    <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_vs_prev     <= VSYNC_i;
            r_de_prev     <= DE_i;
            wr_en_o       <= w_wr;
            line_done_o   <= w_commit;
            frame_start_o <= w_fs;
            if (w_fs)
                frame_fid_o <= FID_i;
            if (w_wr) begin
                wr_addr_o <= {r_slot, xpos_i};
                wr_data_o <= {R_i, G_i, B_i};
            end
            if (w_accept) begin
                r_ypos <= ypos_i;
                r_len  <= 12'd1;
            end else if (w_wr && r_len != 12'hfff)
                r_len <= r_len + 12'd1;
            if (w_commit) begin
                line_slot_o <= r_slot;
                line_ypos_o <= r_ypos;
                line_len_o  <= r_len;
            end
            if (!enable_i) begin
                r_slot      <= '0;
                occupancy_o <= '0;
                drop_cnt_o  <= '0;
                overflow_o  <= 1'b0;
            end else if (w_fs) begin
                r_slot      <= '0;
                occupancy_o <= '0;
                drop_cnt_o  <= '0;
            end else begin
                if (w_commit)
                    r_slot <= r_slot + 1'b1;
                occupancy_o <= occupancy_o + (SLOT_BITS+1)'(w_commit) - (SLOT_BITS+1)'(w_rel);
                if (w_drop) begin
                    overflow_o <= 1'b1;
                    if (drop_cnt_o != 8'hff)
                        drop_cnt_o <= drop_cnt_o + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_frontend_linebuf_writer.sv
// tb_frontend_linebuf_writer: randomized line/frame stimulus checked against a line-level
// scoreboard model of slot allocation, occupancy and drop accounting.
module tb_frontend_linebuf_writer;
    localparam int SB = 2;
    localparam int NS = 1 << SB;

    logic           PCLK_i = 0, reset_n = 0, enable_i = 0, VSYNC_i = 1, DE_i = 0, FID_i = 0, release_i = 0;
    logic [7:0]     R_i = 0, G_i = 0, B_i = 0;
    logic [10:0]    xpos_i = 0, ypos_i = 0;
    logic           wr_en_o, line_done_o, frame_start_o, frame_fid_o, overflow_o;
    logic [SB+10:0] wr_addr_o;
    logic [23:0]    wr_data_o;
    logic [SB-1:0]  line_slot_o;
    logic [10:0]    line_ypos_o;
    logic [11:0]    line_len_o;
    logic [SB:0]    occupancy_o;
    logic [7:0]     drop_cnt_o;

    int total = 0, bad = 0;
    int occ = 0, slot = 0, drops = 0;
    bit ovf = 0, active = 0;
    logic [SB+34:0] wq[$];
    logic [SB+22:0] dq[$];

    frontend_linebuf_writer #(.SLOT_BITS(SB)) dut (
        .PCLK_i(PCLK_i), .reset_n(reset_n), .enable_i(enable_i),
        .R_i(R_i), .G_i(G_i), .B_i(B_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i), .FID_i(FID_i),
        .xpos_i(xpos_i), .ypos_i(ypos_i), .release_i(release_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .line_done_o(line_done_o), .line_slot_o(line_slot_o), .line_ypos_o(line_ypos_o),
        .line_len_o(line_len_o), .frame_start_o(frame_start_o), .frame_fid_o(frame_fid_o),
        .occupancy_o(occupancy_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    always #5 PCLK_i = ~PCLK_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge PCLK_i);
        #1;
    endtask

    always @(negedge PCLK_i) if (reset_n) begin
        if (wr_en_o) begin
            if (wq.size() == 0) chk("wr_extra", 1, 0);
            else chk("wr_addr_data", {wr_addr_o, wr_data_o}, wq.pop_front());
        end
        if (line_done_o) begin
            if (dq.size() == 0) chk("done_extra", 1, 0);
            else chk("done_slot_ypos_len", {line_slot_o, line_ypos_o, line_len_o}, dq.pop_front());
        end
    end

    task automatic check_counts(input string tag);
        chk({tag, "_occ"}, occupancy_o, occ);
        chk({tag, "_drop"}, drop_cnt_o, drops);
        chk({tag, "_ovf"}, overflow_o, ovf);
    endtask

    task automatic frame(input bit f);
        VSYNC_i = 1; DE_i = 0; release_i = 0;
        cyc();
        VSYNC_i = 0; FID_i = f;
        cyc();
        active = 1; occ = 0; slot = 0; drops = 0;
        chk("fs_pulse", frame_start_o, 1);
        chk("fs_fid", frame_fid_o, f);
        cyc();
        chk("fs_end", frame_start_o, 0);
        check_counts("fs");
    endtask

    task automatic line(input int y, input int len, input bit rel);
        bit acc, drp;
        acc = active && occ < NS;
        drp = active && occ >= NS;
        ypos_i = 11'(y); DE_i = 1; release_i = 0;
        for (int i = 0; i < len; i++) begin
            xpos_i = 11'(i);
            {R_i, G_i, B_i} = 24'($urandom);
            if (acc) wq.push_back({SB'(slot), xpos_i, R_i, G_i, B_i});
            cyc();
            chk("wr_en", wr_en_o, acc);
        end
        DE_i = 0; release_i = rel;
        if (acc) dq.push_back({SB'(slot), 11'(y), 12'(len > 4095 ? 4095 : len)});
        cyc();
        release_i = 0;
        chk("line_done", line_done_o, acc);
        if (rel && occ > 0) occ--;
        if (acc) begin occ++; slot = (slot + 1) % NS; end
        if (drp) begin ovf = 1; if (drops < 255) drops++; end
        check_counts("line");
    endtask

    task automatic gap(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            release_i = $urandom_range(99) < pct;
            cyc();
            if (release_i && occ > 0) occ--;
        end
        release_i = 0;
        check_counts("gap");
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_wr_en", wr_en_o, 0);
        chk("rst_addr", wr_addr_o, 0);
        chk("rst_data", wr_data_o, 0);
        chk("rst_done", line_done_o, 0);
        chk("rst_len", line_len_o, 0);
        chk("rst_fs", frame_start_o, 0);
        chk("rst_fid", frame_fid_o, 0);
        check_counts("rst");
        reset_n = 1; enable_i = 1;
        cyc();
        // three full lines without release
        frame(0);
        for (int y = 0; y < 3; y++) line(y, 720, 0);
        chk("three_lines_occ", occupancy_o, 3);
        // ring full: lines 5 and 6 dropped
        frame(1);
        for (int y = 0; y < 6; y++) line(y, 20, 0);
        chk("full_occ", occupancy_o, 4);
        chk("full_drops", drop_cnt_o, 2);
        chk("full_ovf", overflow_o, 1);
        // release coinciding with commit, then release at zero
        frame(0);
        line(0, 8, 0);
        line(1, 8, 1);
        chk("rel_commit_occ", occupancy_o, 1);
        gap(1, 100);
        gap(1, 100);
        chk("rel_zero_occ", occupancy_o, 0);
        // vsync falls mid-line at xpos 300
        frame(1);
        line(0, 10, 0);
        DE_i = 1; ypos_i = 11'd9;
        for (int x = 0; x <= 300; x++) begin
            xpos_i = 11'(x);
            {R_i, G_i, B_i} = 24'($urandom);
            VSYNC_i = (x == 299);
            if (x < 300) wq.push_back({SB'(slot), xpos_i, R_i, G_i, B_i});
            FID_i = 0;
            cyc();
            if (x == 300) begin
                active = 1; occ = 0; slot = 0; drops = 0;
                chk("mid_fs_pulse", frame_start_o, 1);
            end
            chk("mid_wr_en", wr_en_o, x < 300);
        end
        for (int x = 301; x < 304; x++) begin
            xpos_i = 11'(x);
            cyc();
            chk("mid_hold_wr_en", wr_en_o, 0);
        end
        DE_i = 0;
        cyc();
        chk("mid_no_done", line_done_o, 0);
        chk("mid_occ0", occupancy_o, 0);
        line(5, 12, 0);
        chk("mid_occ1", occupancy_o, 1);
        // saturated length, then disable mid-line
        frame(0);
        line(7, 5000, 0);
        chk("sat_len", line_len_o, 4095);
        DE_i = 1; ypos_i = 11'd8;
        for (int x = 0; x < 10; x++) begin
            xpos_i = 11'(x);
            {R_i, G_i, B_i} = 24'($urandom);
            wq.push_back({SB'(slot), xpos_i, R_i, G_i, B_i});
            cyc();
        end
        enable_i = 0;
        cyc();
        active = 0; occ = 0; slot = 0; drops = 0; ovf = 0;
        chk("dis_wr_en", wr_en_o, 0);
        check_counts("dis");
        DE_i = 0;
        cyc();
        chk("dis_no_done", line_done_o, 0);
        enable_i = 1;
        gap(2, 0);
        line(3, 10, 0);
        line(4, 6, 1);
        // randomized frames
        for (int f = 0; f < 6; f++) begin
            frame(1'($urandom));
            for (int n = $urandom_range(4, 9); n > 0; n--) begin
                line($urandom_range(0, 1079), $urandom_range(1, 40), 1'($urandom));
                gap($urandom_range(0, 3), 40);
            end
        end
        gap(3, 0);
        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
